diffusion_round_ctrl: RTL and testbench

Iterative round sequencer for the diffusion layer (ShiftRows, MixColumns) plus AddRoundKey on a 128-bit block state. It accepts one block and requests one round key per round over a handshake. It runs NR rounds, skipping MixColumns in the final round, and returns the result over a valid/ready output. The block sits between the confusion/byte-substitution stage and the key schedule, and owns the single state register that the round datapath loops on.

---
 rtl/diffusion_round_ctrl.sv | 136 +++++++++++++
 tb/tb_diffusion_round_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/diffusion_round_ctrl.sv
// Iterative ShiftRows / MixColumns / AddRoundKey sequencer on a 128-bit block.
// Requests round keys 0..NR in order and returns the block over valid/ready.
module diffusion_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_state,
    input  logic          key_valid,
    output logic          key_ready,
    output logic [RW-1:0] key_round,
    input  logic [127:0]  key_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_state,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ARK0, ROUND, DONE} state_t;

    state_t        state;
    logic [127:0]  s;
    logic [RW-1:0] r;
    logic [127:0]  sr_state;
    logic [127:0]  mc_state;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Byte (row, col) lives at index 4*col+row, counted from the MSB end.
    function automatic logic [127:0] shift_rows(input logic [127:0] x);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                o[127-8*(4*c+rr) -: 8] = x[127-8*(4*((c+rr)%4)+rr) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_column(x[127-32*c -: 32]);
        end
        return o;
    endfunction

    assign sr_state = shift_rows(s);
    assign mc_state = mix_columns(sr_state);

    // DONE spends its first cycle loading the output register, so out_state
    // is a clean register copy for the whole time out_valid is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= '0;
            r         <= '0;
            in_ready  <= 1'b1;
            key_ready <= 1'b0;
            key_round <= '0;
            out_valid <= 1'b0;
            out_state <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s         <= in_state;
                        r         <= '0;
                        state     <= ARK0;
                        in_ready  <= 1'b0;
                        key_ready <= 1'b1;
                        key_round <= '0;
                        busy      <= 1'b1;
                    end
                end
                ARK0: begin
                    if (key_valid) begin
                        s         <= s ^ key_data;
                        r         <= RW'(1);
                        key_round <= RW'(1);
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    if (key_valid) begin
                        if (r < RW'(NR)) begin
                            s         <= mc_state ^ key_data;
                            r         <= r + RW'(1);
                            key_round <= r + RW'(1);
                        end else begin
                            s         <= sr_state ^ key_data;
                            state     <= DONE;
                            key_ready <= 1'b0;
                            key_round <= '0;
                        end
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_state <= s;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_diffusion_round_ctrl.sv
// Bench for diffusion_round_ctrl: three instances (NR=1, 2, 10) driven with
// directed blocks; a monitor pops expected results on each output handshake.
module tb_diffusion_round_ctrl;

    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [127:0] in_state  [NI];
    logic         key_valid [NI];
    logic         key_ready [NI];
    logic [3:0]   key_round [NI];
    logic [127:0] key_data  [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] out_state [NI];
    logic         busy      [NI];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [127:0] exp_q0[$];
    logic [127:0] exp_q1[$];
    logic [127:0] exp_q2[$];

    localparam logic [127:0] C5A  = {16{8'h5a}};
    localparam logic [127:0] MCI  = {4{32'hdb135345}};
    localparam logic [127:0] MCO  = {4{32'h8e4da1bc}};
    localparam logic [127:0] RAMP = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SRO  = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] SRN  = 128'hfffaf5f0fbf6f1fcf7f2fdf8f3fef9f4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        diffusion_round_ctrl #(
            .NR((g == 0) ? 1 : ((g == 1) ? 2 : 10)),
            .RW(4)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .in_state(in_state[g]),
            .key_valid(key_valid[g]),
            .key_ready(key_ready[g]),
            .key_round(key_round[g]),
            .key_data(key_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_state(out_state[g]),
            .busy(busy[g])
        );
    end

    function automatic int nr_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 10);
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push_exp(input int k, input logic [127:0] v);
        case (k)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int k, output logic [127:0] v, output int sz);
        v = '0;
        case (k)
            0: begin sz = exp_q0.size(); if (sz > 0) v = exp_q0.pop_front(); end
            1: begin sz = exp_q1.size(); if (sz > 0) v = exp_q1.pop_front(); end
            default: begin sz = exp_q2.size(); if (sz > 0) v = exp_q2.pop_front(); end
        endcase
    endtask

    task automatic q_size(input int k, output int sz);
        case (k)
            0:       sz = exp_q0.size();
            1:       sz = exp_q1.size();
            default: sz = exp_q2.size();
        endcase
    endtask

    // Monitor: every output handshake must match the oldest expected block.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (out_valid[k] && out_ready[k]) begin : mon_pop
                logic [127:0] e;
                int sz;
                pop_exp(k, e, sz);
                n_vec++;
                if (sz == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected_%0d: got %h expected no output", k, out_state[k]);
                end else if (out_state[k] !== e) begin
                    n_err++;
                    $display("FAIL out_state_%0d: got %h expected %h", k, out_state[k], e);
                end
            end
        end
    end

    task automatic send_block(input int k, input logic [127:0] data, output int t_acc);
        int b;
        b = 0;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_state[k] = data;
        while (!in_ready[k] && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) fail_timeout($sformatf("in_ready_%0d", k));
        @(posedge clk);
        #1;
        t_acc = cyc;
        in_valid[k] = 1'b0;
    endtask

    task automatic serve_keys(input int k, input logic [127:0] key0, input logic [127:0] keyr,
                              input int stall_at, input int stall_n, input int abort_at);
        int idx, st, b;
        idx = 0;
        st = 0;
        b = 0;
        while (idx <= nr_of(k) && b < 200) begin
            @(negedge clk);
            b++;
            key_valid[k] = 1'b0;
            if (key_ready[k]) begin
                if (idx == abort_at) break;
                check($sformatf("key_round_%0d_%0d", k, idx), 128'(key_round[k]), 128'(idx));
                if (idx == stall_at && st < stall_n) begin
                    st++;
                end else begin
                    key_valid[k] = 1'b1;
                    key_data[k]  = (idx == 0) ? key0 : keyr;
                    idx++;
                end
            end
        end
        if (b >= 200) fail_timeout($sformatf("keys_%0d", k));
        if (idx > nr_of(k)) begin
            @(posedge clk);
            #1;
            key_valid[k] = 1'b0;
        end
    endtask

    task automatic wait_out(input int k, input int t_acc, input int exp_lat);
        int b;
        b = 0;
        @(negedge clk);
        while (!out_valid[k] && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) fail_timeout($sformatf("out_valid_%0d", k));
        else check($sformatf("latency_%0d", k), 128'(cyc - t_acc), 128'(exp_lat));
    endtask

    task automatic run(input int k, input logic [127:0] data, input logic [127:0] key0,
                       input logic [127:0] keyr, input int stall_n, input logic [127:0] exp);
        int t;
        push_exp(k, exp);
        send_block(k, data, t);
        serve_keys(k, key0, keyr, 5, stall_n, -1);
        wait_out(k, t, nr_of(k) + 2 + stall_n);
    endtask

    task automatic check_idle(input string tag, input int k);
        check($sformatf("%s_in_ready_%0d", tag, k), 128'(in_ready[k]), 128'(1));
        check($sformatf("%s_busy_%0d", tag, k), 128'(busy[k]), 128'(0));
        check($sformatf("%s_key_ready_%0d", tag, k), 128'(key_ready[k]), 128'(0));
        check($sformatf("%s_out_valid_%0d", tag, k), 128'(out_valid[k]), 128'(0));
    endtask

    initial begin
        int t, sz;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            key_valid[k] = 1'b0;
            key_data[k]  = '0;
            out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check_idle("reset", k);
            check($sformatf("reset_key_round_%0d", k), 128'(key_round[k]), 128'(0));
            check($sformatf("reset_out_state_%0d", k), out_state[k], 128'(0));
        end
        rst_n = 1'b1;

        run(1, C5A, '0, '0, 0, C5A);
        run(1, MCI, '0, '0, 0, MCO);
        run(0, RAMP, '0, '0, 0, SRO);
        run(0, '0, RAMP, {16{8'hff}}, 0, SRN);
        run(2, C5A, '0, '0, 3, C5A);

        // Output backpressure on the NR=2 instance.
        out_ready[1] = 1'b0;
        run(1, MCI, '0, '0, 0, MCO);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_out_valid_%0d", i), 128'(out_valid[1]), 128'(1));
            check($sformatf("bp_out_state_%0d", i), out_state[1], MCO);
            check($sformatf("bp_in_ready_%0d", i), 128'(in_ready[1]), 128'(0));
        end
        @(posedge clk);
        #1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_idle("bp_release", 1);

        // Reset while in ROUND at r=3; the aborted block must never appear.
        send_block(2, RAMP, t);
        serve_keys(2, '0, '0, -1, 0, 3);
        check("abort_key_round", 128'(key_round[2]), 128'(3));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("abort", 2);
        run(2, C5A, '0, '0, 0, C5A);

        repeat (4) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            q_size(k, sz);
            check($sformatf("queue_empty_%0d", k), 128'(sz), 128'(0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
